bcd_field_bank: RTL and testbench
=================================

# bcd_field_bank

Parametrised register bank holding NUM_FIELDS two-digit BCD fields (date, month, year, clock h/m/s, timer h/m/s) written from the decenas/unidades entry path by field address. It replaces the per-digit demultiplexers and fixed per-field inverse decoders feeding the text generator. Each write is range-checked against a per-field limit and acknowledged. Selected fields are presented inverted (FIELD_MAX − value) on a registered output bus read by the VGA text generator.

## Interface
- NUM_FIELDS, 9, number of two-digit BCD fields.
- ADDR_W, 4, field address width; must satisfy 2^ADDR_W ≥ NUM_FIELDS.
- FIELD_MAX, {8'h59,8'h59,8'h23,8'h59,8'h59,8'h23,8'h99,8'h12,8'h31}, packed BCD maximum per field; field i in bits [8i+7:8i].
- MIN1_MASK, 9'b000000011, bit i set: value 00 is illegal for field i, reset value 01.
- INV_MASK, 9'b111000000, bit i set: field i output is FIELD_MAX[i] − stored value.

- clk  in  1  system clock (reloj domain); all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- clear_i  in  1  synchronous reload of every field to its reset value.
- wr_en  in  1  write request, sampled each cycle.
- addr  in  ADDR_W  target field index (direccion).
- dec_i  in  4  tens digit (decenas).
- uni_i  in  4  units digit (unidades).
- wr_ack  out  1  one-cycle pulse: write accepted.
- wr_err  out  1  one-cycle pulse: write rejected.
- fields_o  out  8*NUM_FIELDS  registered display values, field i in [8i+7:8i], tens in the high nibble.

## Operation
- Storage: store[i], 8-bit BCD per field. Reset value 8'h01 if MIN1_MASK[i], else 8'h00.
- Write validation (stage 1, at the sampling edge): the write is legal iff all of:
  - addr < NUM_FIELDS;
  - dec_i ≤ 9 and uni_i ≤ 9;
  - {dec_i,uni_i} ≤ FIELD_MAX[addr], compared as binary value tens*10+units;
  - not (MIN1_MASK[addr] and value = 0).
- Legal write: store[addr] ← {dec_i,uni_i}, wr_ack=1. Illegal write: no state change, wr_err=1. wr_ack and wr_err are never both high.
- Back-to-back writes are accepted every cycle with no busy state. Successive writes to the same field: the last one wins.
- clear_i: all store[i] ← reset value. A wr_en sampled in the same cycle is discarded with wr_ack=wr_err=0. clear_i has priority over writes.
- Output stage (stage 2): fields_o[i] ← INV_MASK[i] ? bcd(bin(FIELD_MAX[i]) − bin(store[i])) : store[i].
  - Arithmetic is 7-bit binary, converted back to BCD. No underflow is possible because store ≤ max is guaranteed.
- wr_en=0 and clear_i=0: all state holds, outputs hold, pulses low.

## Timing
- Write or clear sampled at edge N: store updated and wr_ack/wr_err valid in cycle N+1 (one-cycle pulse); fields_o reflects the change from edge N+2.
- Latency input→display is 2 clocks. Acknowledge latency is 1 clock.
- reset asserted at any time, including mid-pipeline: asynchronously store = reset values, wr_ack=wr_err=0, and fields_o = output function of the reset values. For example, with defaults: field0=8'h01, field6=8'h23, fields 7 and 8 = 8'h59.
- reset deassertion: the first write may be sampled on the first rising edge after release.

## Test plan
- Reset: assert reset mid-cycle → fields_o immediately = {59,59,23,00,00,00,00,01,01} (field8…field0), wr_ack=wr_err=0.
- Legal write: addr=3, dec=2, uni=1 → wr_ack at N+1, fields_o[31:24]=8'h21 at N+2. Then addr=8, value 15 → fields_o[71:64]=8'h44.
- Range rejection: addr=3 value 24; addr=1 value 00; addr=0 value 32; dec_i=4'hA; addr=9 → each gives wr_err at N+1 with fields_o unchanged.
- Back-to-back: writes to addr=5 of 10, 20, 30 on consecutive cycles → three wr_ack pulses, final fields_o[47:40]=8'h30; the intermediate values appear one cycle each.
- clear_i with a simultaneous wr_en (addr=4, value 45) after prior writes → no ack, no err; all fields back to reset values at N+2.
- Parameter sweep: NUM_FIELDS=4, ADDR_W=2, INV_MASK=4'b1000, FIELD_MAX field3=8'h09 → write 3 to field3 gives output 8'h06; write 10 gives wr_err.

Source files
------------

// File: rtl/bcd_field_bank.sv
// Bank of two-digit BCD fields written from the decenas/unidades entry path.
// Each field range-checks its own writes and drives a registered, optionally inverted, display value.

module bcd_field_slot #(
  parameter logic [7:0] MAX  = 8'h99,
  parameter bit         MIN1 = 1'b0,
  parameter bit         INV  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_i,
  input  logic       sel,
  input  logic [3:0] dec_i,
  input  logic [3:0] uni_i,
  output logic       ok,
  output logic [7:0] disp
);
  localparam logic [7:0] RST = MIN1 ? 8'h01 : 8'h00;

  function automatic logic [6:0] to_bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  // Inversion cannot underflow: only values <= MAX are ever stored.
  function automatic logic [7:0] out_fn(input logic [7:0] s);
    return INV ? to_bcd(to_bin(MAX) - to_bin(s)) : s;
  endfunction

  logic [7:0] store;
  logic       legal;

  always_comb begin
    legal = (dec_i <= 4'd9) && (uni_i <= 4'd9)
         && (to_bin({dec_i, uni_i}) <= to_bin(MAX))
         && !(MIN1 && dec_i == 4'd0 && uni_i == 4'd0);
    ok    = sel && legal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      store <= RST;
      disp  <= out_fn(RST);
    end else begin
      if (clear_i)  store <= RST;
      else if (ok)  store <= {dec_i, uni_i};
      disp <= out_fn(store);
    end
  end
endmodule

module bcd_field_bank #(
  parameter int                          NUM_FIELDS = 9,
  parameter int                          ADDR_W     = 4,
  parameter logic [8*NUM_FIELDS-1:0]     FIELD_MAX  = 72'h59_59_23_59_59_23_99_12_31,
  parameter logic [NUM_FIELDS-1:0]       MIN1_MASK  = 9'b000000011,
  parameter logic [NUM_FIELDS-1:0]       INV_MASK   = 9'b111000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [3:0]              dec_i,
  input  logic [3:0]              uni_i,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic [8*NUM_FIELDS-1:0] fields_o
);
  logic [NUM_FIELDS-1:0]      ok;
  logic [NUM_FIELDS-1:0][7:0] disp;
  logic                       wr_live;

  // A write coinciding with clear is dropped silently.
  assign wr_live = wr_en && !clear_i;

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    bcd_field_slot #(
      .MAX  (FIELD_MAX[8*i +: 8]),
      .MIN1 (MIN1_MASK[i]),
      .INV  (INV_MASK[i])
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_i),
      .sel     (wr_live && (addr == ADDR_W'(i))),
      .dec_i   (dec_i),
      .uni_i   (uni_i),
      .ok      (ok[i]),
      .disp    (disp[i])
    );
  end

  assign fields_o = disp;

  // Out-of-range addresses select no slot, so they fall through to wr_err.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_live && (|ok);
      wr_err <= wr_live && !(|ok);
    end
  end
endmodule

// File: tb/tb_bcd_field_bank.sv
// Directed bench for bcd_field_bank: vector table plus hand sequences for pipeline corners.

module tb_bcd_field_bank;
  localparam logic [71:0] RST_F = 72'h59_59_23_00_00_00_00_01_01;

  logic        clk = 1'b0;
  logic        reset, clear_i, wr_en, wr_en4;
  logic [3:0]  addr, dec_i, uni_i;
  logic [1:0]  addr4;
  logic        wr_ack, wr_err, wr_ack4, wr_err4;
  logic [71:0] fields_o;
  logic [31:0] fields4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bcd_field_bank dut (
    .clk(clk), .reset(reset), .clear_i(clear_i), .wr_en(wr_en), .addr(addr),
    .dec_i(dec_i), .uni_i(uni_i), .wr_ack(wr_ack), .wr_err(wr_err), .fields_o(fields_o)
  );

  bcd_field_bank #(
    .NUM_FIELDS(4), .ADDR_W(2), .FIELD_MAX(32'h09_99_99_99),
    .MIN1_MASK(4'b0000), .INV_MASK(4'b1000)
  ) dut4 (
    .clk(clk), .reset(reset), .clear_i(clear_i), .wr_en(wr_en4), .addr(addr4),
    .dec_i(dec_i), .uni_i(uni_i), .wr_ack(wr_ack4), .wr_err(wr_err4), .fields_o(fields4)
  );

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  d;
    logic [3:0]  u;
    logic        ack;
    logic        err;
    logic [71:0] f;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear_i = 1'b0; wr_en = 1'b0; wr_en4 = 1'b0;
    addr = '0; addr4 = '0; dec_i = '0; uni_i = '0;
    #2;
    chk("reset_fields", fields_o, RST_F);
    chk("reset_ack", {71'd0, wr_ack}, 72'd0);
    chk("reset_err", {71'd0, wr_err}, 72'd0);
    chk("reset_fields4", {40'd0, fields4}, {40'd0, 32'h09_00_00_00});
    #10 reset = 1'b0;
    tick();

    vt[0]  = '{4'd3, 4'd2, 4'd1, 1'b1, 1'b0, 72'h59_59_23_00_00_21_00_01_01};
    vt[1]  = '{4'd8, 4'd1, 4'd5, 1'b1, 1'b0, 72'h44_59_23_00_00_21_00_01_01};
    vt[2]  = '{4'd3, 4'd2, 4'd4, 1'b0, 1'b1, 72'h44_59_23_00_00_21_00_01_01};
    vt[3]  = '{4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 72'h44_59_23_00_00_21_00_01_01};
    vt[4]  = '{4'd0, 4'd3, 4'd2, 1'b0, 1'b1, 72'h44_59_23_00_00_21_00_01_01};
    vt[5]  = '{4'd2, 4'hA, 4'd0, 1'b0, 1'b1, 72'h44_59_23_00_00_21_00_01_01};
    vt[6]  = '{4'd9, 4'd0, 4'd1, 1'b0, 1'b1, 72'h44_59_23_00_00_21_00_01_01};
    vt[7]  = '{4'd0, 4'd3, 4'd1, 1'b1, 1'b0, 72'h44_59_23_00_00_21_00_01_31};
    vt[8]  = '{4'd6, 4'd2, 4'd3, 1'b1, 1'b0, 72'h44_59_00_00_00_21_00_01_31};
    vt[9]  = '{4'd2, 4'd9, 4'd9, 1'b1, 1'b0, 72'h44_59_00_00_00_21_99_01_31};
    vt[10] = '{4'd4, 4'd5, 4'hA, 1'b0, 1'b1, 72'h44_59_00_00_00_21_99_01_31};
    vt[11] = '{4'd7, 4'd0, 4'd9, 1'b1, 1'b0, 72'h44_50_00_00_00_21_99_01_31};

    for (int k = 0; k < 12; k++) begin
      wr_en = 1'b1; addr = vt[k].a; dec_i = vt[k].d; uni_i = vt[k].u;
      tick();
      wr_en = 1'b0;
      chk($sformatf("vec%0d_ack", k), {71'd0, wr_ack}, {71'd0, vt[k].ack});
      chk($sformatf("vec%0d_err", k), {71'd0, wr_err}, {71'd0, vt[k].err});
      tick();
      chk($sformatf("vec%0d_fields", k), fields_o, vt[k].f);
      chk($sformatf("vec%0d_ack_pulse", k), {71'd0, wr_ack | wr_err}, 72'd0);
    end

    // Back-to-back writes to field 5: each value visible for one cycle.
    wr_en = 1'b1; addr = 4'd5; dec_i = 4'd1; uni_i = 4'd0;
    tick();
    chk("b2b_ack1", {71'd0, wr_ack}, 72'd1);
    dec_i = 4'd2;
    tick();
    chk("b2b_ack2", {71'd0, wr_ack}, 72'd1);
    chk("b2b_f5_10", {64'd0, fields_o[47:40]}, 72'h10);
    dec_i = 4'd3;
    tick();
    chk("b2b_ack3", {71'd0, wr_ack}, 72'd1);
    chk("b2b_f5_20", {64'd0, fields_o[47:40]}, 72'h20);
    wr_en = 1'b0;
    tick();
    chk("b2b_ack_done", {71'd0, wr_ack}, 72'd0);
    chk("b2b_f5_30", {64'd0, fields_o[47:40]}, 72'h30);

    // Clear with a simultaneous legal write: write dropped, no pulses.
    clear_i = 1'b1; wr_en = 1'b1; addr = 4'd4; dec_i = 4'd4; uni_i = 4'd5;
    tick();
    clear_i = 1'b0; wr_en = 1'b0;
    chk("clr_ack", {71'd0, wr_ack}, 72'd0);
    chk("clr_err", {71'd0, wr_err}, 72'd0);
    tick();
    chk("clr_fields", fields_o, RST_F);

    // Reset mid-pipeline: ack pending and display about to change.
    wr_en = 1'b1; addr = 4'd8; dec_i = 4'd0; uni_i = 4'd9;
    tick();
    wr_en = 1'b0;
    chk("pre_rst_ack", {71'd0, wr_ack}, 72'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ack", {71'd0, wr_ack}, 72'd0);
    chk("midrst_fields", fields_o, RST_F);
    tick();
    chk("midrst_hold", fields_o, RST_F);
    #2 reset = 1'b0;
    // First write sampled on the first edge after release.
    wr_en = 1'b1; addr = 4'd3; dec_i = 4'd1; uni_i = 4'd2;
    tick();
    wr_en = 1'b0;
    chk("postrst_ack", {71'd0, wr_ack}, 72'd1);
    tick();
    chk("postrst_fields", fields_o, 72'h59_59_23_00_00_12_00_01_01);

    // Narrow instance: field 3 max 09, inverted.
    wr_en4 = 1'b1; addr4 = 2'd3; dec_i = 4'd0; uni_i = 4'd3;
    tick();
    chk("p4_ack", {71'd0, wr_ack4}, 72'd1);
    dec_i = 4'd1; uni_i = 4'd0;
    tick();
    wr_en4 = 1'b0;
    chk("p4_err", {71'd0, wr_err4}, 72'd1);
    chk("p4_f3_06", {64'd0, fields4[31:24]}, 72'h06);
    tick();
    chk("p4_f3_hold", {40'd0, fields4}, {40'd0, 32'h06_00_00_00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
